anita3_pps_conditioner: RTL and testbench

//  Selects one of two GPS PPS sources, synchronises it to clk33_i and rejects glitches by interval window.

---
 rtl/anita3_pps_conditioner_pkg.sv | 25 ++
 rtl/anita3_pps_sync_edge.sv | 29 ++
 rtl/anita3_pps_conditioner.sv | 187 ++++++++++++++++++
 tb/tb_anita3_pps_conditioner.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/anita3_pps_conditioner_pkg.sv
// Shared definitions for the ANITA-3 PPS conditioner: state encodings, counter width, default periods.
// The optional holdover feature is enabled by defining PPS_HOLDOVER_EN.
package anita3_pps_conditioner_pkg;

  localparam int CNT_W = 26;

  localparam int MIN_PERIOD_DEF   = 29_700_000;
  localparam int MAX_PERIOD_DEF   = 36_300_000;
  localparam int LOCK_COUNT_DEF   = 3;
  localparam int PULSE_WIDTH_DEF  = 4;
  localparam int HOLDOVER_MAX_DEF = 10;

  typedef enum logic [1:0] {
    ST_ACQUIRE  = 2'd0,
    ST_TRACK    = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOVER = 2'd3
  } pps_state_t;

  // Interval counter increments but sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/anita3_pps_sync_edge.sv
// Two-flop synchroniser plus edge register for one asynchronous PPS input; emits a registered rise strobe.
// reload suppresses the strobe for a cycle so a freshly selected source cannot produce a false edge.
module anita3_pps_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic reload,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
      rise <= sync & ~prev & ~reload;
    end
  end

endmodule

// File: rtl/anita3_pps_conditioner.sv
// PPS source select, glitch rejection by interval window, fixed-width output pulse, lock/missing status.
// Define PPS_HOLDOVER_EN to synthesise missing pulses after a LOCKED timeout (holdover).
module anita3_pps_conditioner
  import anita3_pps_conditioner_pkg::*;
#(
  parameter int MIN_PERIOD  = MIN_PERIOD_DEF,
  parameter int MAX_PERIOD  = MAX_PERIOD_DEF,
  parameter int LOCK_COUNT  = LOCK_COUNT_DEF,
  parameter int PULSE_WIDTH = PULSE_WIDTH_DEF
`ifdef PPS_HOLDOVER_EN
  ,
  parameter int HOLDOVER_MAX = HOLDOVER_MAX_DEF
`endif
) (
  input  logic             clk33_i,
  input  logic             rst_n_i,
  input  logic             pps_a_i,
  input  logic             pps_b_i,
  input  logic             sel_i,
  output logic             pps_o,
  output logic             pps_valid_o,
  output logic             pps_missing_o,
  output logic             glitch_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_stb_o,
  output pps_state_t       state_o
);

  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_PERIOD);
  localparam logic [7:0]       LOCK_C = 8'(LOCK_COUNT);
  localparam logic [7:0]       PW_C   = 8'(PULSE_WIDTH - 1);
`ifdef PPS_HOLDOVER_EN
  localparam logic [7:0]       HOLD_C = 8'(HOLDOVER_MAX);
`endif

  logic             sel_q;
  logic             sel_chg;
  logic             rise_a;
  logic             rise_b;
  logic             edge_det;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_now;
  logic [7:0]       good;
  logic [7:0]       pw;
  pps_state_t       state;
`ifdef PPS_HOLDOVER_EN
  logic [7:0]       hold_n;
`endif

  anita3_pps_sync_edge u_sync_a (
    .clk    (clk33_i),
    .rst_n  (rst_n_i),
    .pin    (pps_a_i),
    .reload (sel_chg),
    .rise   (rise_a)
  );

  anita3_pps_sync_edge u_sync_b (
    .clk    (clk33_i),
    .rst_n  (rst_n_i),
    .pin    (pps_b_i),
    .reload (sel_chg),
    .rise   (rise_b)
  );

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) sel_q <= 1'b0;
    else          sel_q <= sel_i;
  end

  // cnt_now is the interval that ends at this clock, measured between processing cycles.
  assign sel_chg  = sel_i ^ sel_q;
  assign edge_det = sel_q ? rise_b : rise_a;
  assign cnt_now  = sat_inc(cnt);
  assign state_o  = state;

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= ST_ACQUIRE;
      cnt           <= '0;
      good          <= '0;
      pw            <= '0;
      pps_o         <= 1'b0;
      pps_valid_o   <= 1'b0;
      pps_missing_o <= 1'b0;
      glitch_o      <= 1'b0;
      period_o      <= '0;
      period_stb_o  <= 1'b0;
`ifdef PPS_HOLDOVER_EN
      hold_n        <= '0;
`endif
    end else begin
      glitch_o     <= 1'b0;
      period_stb_o <= 1'b0;
      cnt          <= cnt_now;
      if (pps_o) begin
        if (pw == '0) pps_o <= 1'b0;
        else          pw    <= pw - 8'd1;
      end

      if (sel_chg) begin
        state         <= ST_ACQUIRE;
        cnt           <= '0;
        good          <= '0;
        pps_valid_o   <= 1'b0;
        pps_missing_o <= 1'b0;
      end else begin
        case (state)
          ST_ACQUIRE: begin
            if (edge_det) begin
              pps_o         <= 1'b1;
              pw            <= PW_C;
              cnt           <= '0;
              good          <= '0;
              pps_missing_o <= 1'b0;
              state         <= ST_TRACK;
            end
          end
          ST_TRACK, ST_LOCKED: begin
            if (edge_det) begin
              if (cnt_now < MIN_C) begin
                glitch_o <= 1'b1;
              end else begin
                pps_o         <= 1'b1;
                pw            <= PW_C;
                cnt           <= '0;
                period_o      <= cnt_now;
                period_stb_o  <= 1'b1;
                pps_missing_o <= 1'b0;
                if (state == ST_TRACK) begin
                  good <= good + 8'd1;
                  if (good + 8'd1 >= LOCK_C) begin
                    state       <= ST_LOCKED;
                    pps_valid_o <= 1'b1;
                  end
                end
              end
            end else if (cnt_now == MAX_C) begin
              pps_missing_o <= 1'b1;
              pps_valid_o   <= 1'b0;
              state         <= ST_ACQUIRE;
`ifdef PPS_HOLDOVER_EN
              if (state == ST_LOCKED) begin
                state       <= ST_HOLDOVER;
                pps_valid_o <= 1'b1;
                pps_o       <= 1'b1;
                pw          <= PW_C;
                cnt         <= '0;
                hold_n      <= 8'd1;
              end
`endif
            end
          end
`ifdef PPS_HOLDOVER_EN
          ST_HOLDOVER: begin
            if (edge_det) begin
              pps_o         <= 1'b1;
              pw            <= PW_C;
              cnt           <= '0;
              good          <= '0;
              pps_missing_o <= 1'b0;
              pps_valid_o   <= 1'b0;
              state         <= ST_TRACK;
            end else if (cnt_now == period_o) begin
              if (hold_n >= HOLD_C) begin
                state       <= ST_ACQUIRE;
                pps_valid_o <= 1'b0;
              end else begin
                pps_o  <= 1'b1;
                pw     <= PW_C;
                cnt    <= '0;
                hold_n <= hold_n + 8'd1;
              end
            end
          end
`endif
          default: begin
            state       <= ST_ACQUIRE;
            pps_valid_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_anita3_pps_conditioner.sv
// Directed bench for anita3_pps_conditioner with a pulse scoreboard; honours PPS_HOLDOVER_EN when defined.
module tb_anita3_pps_conditioner;
  import anita3_pps_conditioner_pkg::*;

  localparam int W = 59;  // {cycle[31:0], period_stb, period[25:0]}

  logic             clk33 = 1'b0;
  logic             rst_n;
  logic             pps_a;
  logic             pps_b;
  logic             sel;
  logic             pps_o;
  logic             pps_valid;
  logic             pps_missing;
  logic             glitch;
  logic [CNT_W-1:0] period;
  logic             period_stb;
  pps_state_t       state;

  int               cyc = 0;
  int               n_assert = 0;
  int               n_fail = 0;
  int               glitch_cnt = 0;
  int               high_cnt = 0;
  logic             pps_prev = 1'b0;
  logic             glitch_prev = 1'b0;
  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     e;

  anita3_pps_conditioner #(
    .MIN_PERIOD  (90),
    .MAX_PERIOD  (110),
    .LOCK_COUNT  (3),
    .PULSE_WIDTH (4)
`ifdef PPS_HOLDOVER_EN
    ,
    .HOLDOVER_MAX(2)
`endif
  ) dut (
    .clk33_i       (clk33),
    .rst_n_i       (rst_n),
    .pps_a_i       (pps_a),
    .pps_b_i       (pps_b),
    .sel_i         (sel),
    .pps_o         (pps_o),
    .pps_valid_o   (pps_valid),
    .pps_missing_o (pps_missing),
    .glitch_o      (glitch),
    .period_o      (period),
    .period_stb_o  (period_stb),
    .state_o       (state)
  );

  // Clock and cycle counter
  always #15 clk33 = ~clk33;
  always @(posedge clk33) cyc <= cyc + 1;

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge clk33);
      #1;
    end
  endtask

  task automatic expect_pulse(input int at, input logic stb, input int per);
    exp_q.push_back({32'(at), stb, 26'(per)});
  endtask

  // Input edge at the current cycle; held high for 10 cycles.
  task automatic drive_edge(input logic src_b, input logic push, input logic stb, input int per);
    int d;
    d = cyc;
    if (src_b) pps_b = 1'b1;
    else       pps_a = 1'b1;
    if (push) expect_pulse(d + 4, stb, per);
    step_to(d + 10);
    if (src_b) pps_b = 1'b0;
    else       pps_a = 1'b0;
  endtask

  // Scoreboard / monitor, sampled on the falling edge
  always @(negedge clk33) begin
    if (!rst_n) begin
      pps_prev    = 1'b0;
      glitch_prev = 1'b0;
      high_cnt    = 0;
    end else begin
      if (pps_o && !pps_prev) begin
        check("pulse_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pulse_cycle", 64'(cyc), 64'(e[58:27]));
          check("pulse_stb", 64'(period_stb), 64'(e[26]));
          if (e[26]) check("pulse_period", 64'(period), 64'(e[25:0]));
        end
      end
      if (period_stb) check("stb_on_rise", 64'({pps_o, pps_prev}), 64'(2'b10));
      if (!pps_o && pps_prev) check("pulse_width", 64'(high_cnt), 64'd4);
      high_cnt = pps_o ? high_cnt + 1 : 0;
      if (glitch) begin
        glitch_cnt++;
        check("glitch_width", 64'(glitch_prev), 64'd0);
      end
      pps_prev    = pps_o;
      glitch_prev = glitch;
    end
  end

  initial begin
    int d;
    int d6;
    int b;
    int c;
    int g0;
    rst_n = 1'b0;
    pps_a = 1'b0;
    pps_b = 1'b0;
    sel   = 1'b0;
    repeat (3) @(posedge clk33);
    #1;
    check("rst_pps", 64'(pps_o), 64'd0);
    check("rst_valid", 64'(pps_valid), 64'd0);
    check("rst_missing", 64'(pps_missing), 64'd0);
    check("rst_glitch", 64'(glitch), 64'd0);
    check("rst_period", 64'(period), 64'd0);
    check("rst_stb", 64'(period_stb), 64'd0);
    check("rst_state", 64'(state), 64'(ST_ACQUIRE));
    rst_n = 1'b1;
    step_to(cyc + 5);

    // Source A, period 100: lock on the 4th edge
    d = cyc;
    drive_edge(1'b0, 1'b1, 1'b0, 0);
    check("s1_state_track", 64'(state), 64'(ST_TRACK));
    step_to(d + 100);
    drive_edge(1'b0, 1'b1, 1'b1, 100);
    step_to(d + 200);
    drive_edge(1'b0, 1'b1, 1'b1, 100);
    check("s1_valid_before_lock", 64'(pps_valid), 64'd0);
    step_to(d + 300);
    drive_edge(1'b0, 1'b1, 1'b1, 100);
    check("s1_valid_lock", 64'(pps_valid), 64'd1);
    check("s1_state_locked", 64'(state), 64'(ST_LOCKED));
    check("s1_period", 64'(period), 64'd100);
    step_to(d + 400);
    drive_edge(1'b0, 1'b1, 1'b1, 100);

    // Glitch 50 cycles after a pulse, then a good edge at 100
    g0 = glitch_cnt;
    step_to(d + 450);
    drive_edge(1'b0, 1'b0, 1'b0, 0);
    check("s2_glitch_count", 64'(glitch_cnt - g0), 64'd1);
    check("s2_valid_kept", 64'(pps_valid), 64'd1);
    step_to(d + 500);
    drive_edge(1'b0, 1'b1, 1'b1, 100);
    check("s2_no_extra_glitch", 64'(glitch_cnt - g0), 64'd1);

    // Source stops: timeout at 110
    d6 = d + 500;
`ifdef PPS_HOLDOVER_EN
    expect_pulse(d6 + 114, 1'b0, 0);
    expect_pulse(d6 + 214, 1'b0, 0);
`endif
    step_to(d6 + 113);
    check("s3_missing_before", 64'(pps_missing), 64'd0);
    check("s3_valid_before", 64'(pps_valid), 64'd1);
    step_to(d6 + 114);
    check("s3_missing_set", 64'(pps_missing), 64'd1);
`ifdef PPS_HOLDOVER_EN
    check("s3_hold_valid", 64'(pps_valid), 64'd1);
    check("s3_hold_state", 64'(state), 64'(ST_HOLDOVER));
    check("s3_hold_pulse", 64'(pps_o), 64'd1);
    step_to(d6 + 313);
    check("s3_hold_valid_late", 64'(pps_valid), 64'd1);
    check("s3_hold_state_late", 64'(state), 64'(ST_HOLDOVER));
    step_to(d6 + 314);
    check("s3_hold_exit_valid", 64'(pps_valid), 64'd0);
    check("s3_hold_exit_state", 64'(state), 64'(ST_ACQUIRE));
    check("s3_hold_exit_missing", 64'(pps_missing), 64'd1);
`else
    check("s3_valid_drop", 64'(pps_valid), 64'd0);
    check("s3_state_acq", 64'(state), 64'(ST_ACQUIRE));
    step_to(d6 + 314);
    check("s3_missing_sticky", 64'(pps_missing), 64'd1);
    check("s3_pps_quiet", 64'(pps_o), 64'd0);
`endif

    // Relock on A, then switch to B while B is held high
    b = d6 + 400;
    step_to(b);
    drive_edge(1'b0, 1'b1, 1'b0, 0);
    check("s4_missing_cleared", 64'(pps_missing), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      step_to(b + 100 * i);
      drive_edge(1'b0, 1'b1, 1'b1, 100);
    end
    check("s4_locked_a", 64'(pps_valid), 64'd1);
    step_to(b + 320);
    pps_b = 1'b1;
    step_to(b + 340);
    sel = 1'b1;
    step_to(b + 343);
    check("s4_sel_valid", 64'(pps_valid), 64'd0);
    check("s4_sel_missing", 64'(pps_missing), 64'd0);
    check("s4_sel_state", 64'(state), 64'(ST_ACQUIRE));
    step_to(b + 360);
    drive_edge(1'b0, 1'b0, 1'b0, 0);
    step_to(b + 380);
    pps_b = 1'b0;
    step_to(b + 400);
    drive_edge(1'b1, 1'b1, 1'b0, 0);
    check("s4_b_state", 64'(state), 64'(ST_TRACK));
    for (int i = 5; i <= 7; i++) begin
      step_to(b + 100 * i);
      drive_edge(1'b1, 1'b1, 1'b1, 100);
    end
    check("s4_locked_b", 64'(pps_valid), 64'd1);

    // Reset while pps_o is high
    step_to(b + 800);
    pps_b = 1'b1;
    expect_pulse(b + 804, 1'b1, 100);
    step_to(b + 805);
    check("s5_pps_high", 64'(pps_o), 64'd1);
    rst_n = 1'b0;
    sel   = 1'b0;
    #1;
    check("s5_rst_pps", 64'(pps_o), 64'd0);
    check("s5_rst_valid", 64'(pps_valid), 64'd0);
    check("s5_rst_period", 64'(period), 64'd0);
    check("s5_rst_state", 64'(state), 64'(ST_ACQUIRE));
    pps_b = 1'b0;
    step_to(b + 810);
    rst_n = 1'b1;

    // Post-reset acquire on A, then window boundaries 90 and 110
    c = b + 820;
    step_to(c);
    drive_edge(1'b0, 1'b1, 1'b0, 0);
    step_to(c + 100);
    drive_edge(1'b0, 1'b1, 1'b1, 100);
    check("s5_period_100", 64'(period), 64'd100);
    check("s5_valid_track", 64'(pps_valid), 64'd0);
    step_to(c + 190);
    drive_edge(1'b0, 1'b1, 1'b1, 90);
    check("s6_period_90", 64'(period), 64'd90);
    step_to(c + 300);
    drive_edge(1'b0, 1'b1, 1'b1, 110);
    check("s6_period_110", 64'(period), 64'd110);
    check("s6_valid_lock", 64'(pps_valid), 64'd1);
    g0 = glitch_cnt;
    step_to(c + 389);
    drive_edge(1'b0, 1'b0, 1'b0, 0);
    check("s6_glitch_89", 64'(glitch_cnt - g0), 64'd1);
    step_to(c + 410);
    drive_edge(1'b0, 1'b1, 1'b1, 110);
    check("s6_missing_clear", 64'(pps_missing), 64'd0);

    step_to(c + 450);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
